// File: rtl/jpeg_dec_pkg.sv
// Shared types and constants for the JPEG entropy-decode front end.
package jpeg_dec_pkg;

  typedef enum logic [1:0] {
    NORMAL,
    FF_SEEN,
    MARKER
  } unstuff_state_t;

  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] STUFF_BYTE    = 8'h00;
  localparam logic [7:0] EOI           = 8'hD9;
  localparam logic [7:0] RST0          = 8'hD0;
  localparam logic [7:0] RST1          = 8'hD1;
  localparam logic [7:0] RST2          = 8'hD2;
  localparam logic [7:0] RST3          = 8'hD3;
  localparam logic [7:0] RST4          = 8'hD4;
  localparam logic [7:0] RST5          = 8'hD5;
  localparam logic [7:0] RST6          = 8'hD6;
  localparam logic [7:0] RST7          = 8'hD7;

endpackage

// File: rtl/byte_unstuffer.sv
// Strips 0xFF/0x00 stuffing from accepted bytes and captures marker codes;
// emits an append strobe plus the data byte for the bit accumulator.
module byte_unstuffer
  import jpeg_dec_pkg::*;
#(
  parameter bit UNSTUFF = 1'b1
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           i_flush,
  input  logic           i_wait,
  input  logic           i_accept,
  input  logic [7:0]     i_byte,
  output logic           o_append,
  output logic [7:0]     o_append_byte,
  output unstuff_state_t o_state,
  output logic           o_marker,
  output logic [7:0]     o_marker_code
);

  // NOTE: every output of this block gets a default before the case so no latch is inferred.
  always_comb begin
    o_append      = 1'b0;
    o_append_byte = i_byte;
    if (!UNSTUFF) begin
      o_append = i_accept;
    end else if (i_accept) begin
      case (o_state)
        NORMAL:  o_append = (i_byte != MARKER_PREFIX);
        FF_SEEN: begin
          if (i_byte == STUFF_BYTE) begin
            o_append      = 1'b1;
            o_append_byte = MARKER_PREFIX;
          end
        end
        default: o_append = 1'b0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments and a synchronous reset sampled on clk.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      o_state       <= NORMAL;
      o_marker      <= 1'b0;
      o_marker_code <= 8'h00;
    end else if (!i_wait) begin
      o_marker <= 1'b0;
      if (i_flush) begin
        o_state <= NORMAL;
      end else if (UNSTUFF && i_accept) begin
        case (o_state)
          NORMAL: begin
            if (i_byte == MARKER_PREFIX) o_state <= FF_SEEN;
          end
          FF_SEEN: begin
            // A repeated FF is a fill byte: keep waiting for the code byte.
            if (i_byte == STUFF_BYTE) begin
              o_state <= NORMAL;
            end else if (i_byte != MARKER_PREFIX) begin
              o_marker      <= 1'b1;
              o_marker_code <= i_byte;
              o_state       <= MARKER;
            end
          end
          default: o_state <= o_state;
        endcase
      end
    end
  end

endmodule

// File: rtl/bit_unpacker.sv
// Byte-to-bit front end for the Huffman decoder: unstuffed bytes fill a
// left-aligned accumulator, the decoder peeks and consumes bits from its head.
module bit_unpacker
  import jpeg_dec_pkg::*;
#(
  parameter int ACC_WIDTH  = 32,
  parameter int PEEK_WIDTH = 16,
  parameter bit UNSTUFF    = 1'b1,
  localparam int CW = $clog2(ACC_WIDTH + 1),
  localparam int LW = $clog2(PEEK_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_consume,
  input  logic [LW-1:0]         i_consume_len,
  input  logic                  i_align,
  input  logic                  i_flush,
  input  logic                  i_wait,
  output logic [PEEK_WIDTH-1:0] o_peek,
  output logic [CW-1:0]         o_count,
  output logic                  o_marker,
  output logic [7:0]            o_marker_code,
  output logic                  o_underflow
);

  localparam logic [CW-1:0] READY_MAX = CW'(ACC_WIDTH - 8);
  localparam logic [CW-1:0] PEEK_MAX  = CW'(PEEK_WIDTH);
  localparam logic [CW-1:0] BYTE_BITS = CW'(8);

  logic [ACC_WIDTH-1:0] acc, acc_cons, acc_algn, acc_nxt;
  logic [CW-1:0]        cnt_cons, cnt_algn, cnt_nxt, len_ext, shift_len, drop_len;
  logic                 accept, append, bad_consume;
  logic [7:0]           append_byte;
  unstuff_state_t       state;

  assign o_ready = !i_wait && (state != MARKER) && (o_count <= READY_MAX);
  assign accept  = i_valid && o_ready;
  assign o_peek  = acc[ACC_WIDTH-1 -: PEEK_WIDTH];

  byte_unstuffer #(.UNSTUFF(UNSTUFF)) u_unstuffer (
    .clk           (clk),
    .n_rst         (n_rst),
    .i_flush       (i_flush),
    .i_wait        (i_wait),
    .i_accept      (accept),
    .i_byte        (i_data),
    .o_append      (append),
    .o_append_byte (append_byte),
    .o_state       (state),
    .o_marker      (o_marker),
    .o_marker_code (o_marker_code)
  );

  // Consume, then align, then append; each stage works on the previous stage's count.
  always_comb begin
    len_ext     = CW'(i_consume_len);
    bad_consume = i_consume && ((len_ext > PEEK_MAX) || (len_ext > o_count));
    shift_len   = (i_consume && !bad_consume) ? len_ext : '0;
    acc_cons    = acc << shift_len;
    cnt_cons    = o_count - shift_len;
    drop_len    = i_align ? {{(CW-3){1'b0}}, cnt_cons[2:0]} : '0;
    acc_algn    = acc_cons << drop_len;
    cnt_algn    = cnt_cons - drop_len;
    acc_nxt     = acc_algn;
    cnt_nxt     = cnt_algn;
    if (append) begin
      acc_nxt = acc_algn | ({append_byte, {(ACC_WIDTH-8){1'b0}}} >> cnt_algn);
      cnt_nxt = cnt_algn + BYTE_BITS;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc         <= '0;
      o_count     <= '0;
      o_underflow <= 1'b0;
    end else if (!i_wait) begin
      if (i_flush) begin
        acc         <= '0;
        o_count     <= '0;
        o_underflow <= 1'b0;
      end else begin
        acc         <= acc_nxt;
        o_count     <= cnt_nxt;
        o_underflow <= o_underflow | bad_consume;
      end
    end
  end

endmodule
